rf_wb_sched: RTL and testbench
==============================

RF_WB_SCHED -- requirements
Module: rf_wb_sched

Interface
REQ-001 Parameter: W, 8, data path width (matches register file data width).
REQ-002 Parameter: D, 3, register address width; register file depth is 2**D.
REQ-003 Parameter: STARVE, 2, consecutive lost arbitrations before requester A gains priority (range 1..7).
REQ-004 CLK  input  1  clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 a_valid  input  1  ALU writeback request.
REQ-007 a_addr / a_data  input  D / W  ALU destination register and write value.
REQ-008 a_ready  output  1  ALU request accepted this cycle.
REQ-009 b_valid  input  1  load writeback request.
REQ-010 b_addr / b_data  input  D / W  load destination register and write value.
REQ-011 b_ready  output  1  load request accepted this cycle.
REQ-012 hold  input  1  register file write stall (debug/scan); freezes draining.
REQ-013 rf_we  output  1  drives register file write_en.
REQ-014 rf_waddr / rf_wdata  output  D / W  drive register file waddr / data_in.
REQ-015 pend_mask  output  2**D  bit i high while a queued write targets register i.
REQ-016 q_count  output  2  current queue occupancy (0..2).

Function
REQ-017 Two-entry in-order write queue between arbiter and register file write port.
REQ-018 Transfer on a requester occurs when valid && ready in the same cycle; the entry is in the queue after that posedge.
REQ-019 At most one of a_ready / b_ready high per cycle.
REQ-020 Ready requires q_count < 2 (no pass-through: a slot freed by a same-cycle pop is not reusable that cycle).
REQ-021 Default priority: B over A; if both valid and queue not full, b_ready=1, a_ready=0.
REQ-022 Starve counter increments each cycle a_valid=1, b_valid=1, q_count<2 and B wins; saturates at STARVE.
REQ-023 When starve counter == STARVE and both valid with queue not full, A wins (a_ready=1, b_ready=0).
REQ-024 Starve counter clears to 0 on any A transfer or any cycle a_valid=0.
REQ-025 Full queue (q_count=2) does not change the starve counter.
REQ-026 Ready outputs are combinational from registered state and the valid inputs only; no dependence on addr/data.
REQ-027 rf_we = (q_count > 0) && !hold; rf_waddr / rf_wdata = head entry, valid whenever q_count > 0.
REQ-028 Head pops at posedge when rf_we=1; minimum accept-to-rf_we latency 1 cycle (accept at edge N, rf_we in cycle after N).
REQ-029 Simultaneous push and pop: q_count unchanged, new entry placed behind the remaining entry, order preserved.
REQ-030 hold=1: no pop, rf_we=0, accepts continue until q_count=2.
REQ-031 pend_mask = OR of one-hot decodes of all occupied entry addresses; computed from registered state.
REQ-032 Two entries with the same address are kept and written in order (no coalescing); bit stays set until both pop.
REQ-033 Address 0 is an ordinary destination; no blanking or filtering.
REQ-034 When q_count=0, rf_waddr / rf_wdata are don't-care, but rf_we=0.

Reset
REQ-035 reset=1 at posedge: q_count=0, starve counter=0, all entries invalid; queued writes discarded, none issued.
REQ-036 During reset cycle outputs: rf_we=0, pend_mask=0, a_ready=0, b_ready=0.
REQ-037 Reset mid-operation (queue full, hold=1) gives the same state as power-on reset; first accept is possible the cycle after reset deasserts.

Verification
REQ-038 A only: a_valid=1, a_addr=3, a_data=8'h5A, one cycle -> a_ready=1; next cycle rf_we=1, rf_waddr=3, rf_wdata=8'h5A, pend_mask=8'h08; following cycle q_count=0.
REQ-039 Both valid continuously, STARVE=2, hold=0 -> grant sequence B,B,A,B,B,A; starve counter returns to 0 after each A grant.
REQ-040 hold=1 with three b requests (addr 1,2,4) -> first two accepted, third b_ready=0, q_count=2, pend_mask=8'h06; release hold -> writes addr 1 then 2, then addr 4 accepted.
REQ-041 Same address twice (addr 5, data 8'h11 then 8'h22) -> rf writes 8'h11 then 8'h22; pend_mask bit 5 clears only after second pop.
REQ-042 Queue full, assert reset for one cycle -> no rf_we during or after reset; q_count=0, pend_mask=0.
REQ-043 Steady stream of one accept per cycle, hold=0 -> one rf_we per cycle, q_count stays at 1, data order matches accept order.

Source files
------------

// File: rtl/rf_wb_sched.sv
// Register-file writeback scheduler: arbitrates ALU (A) and load (B) writebacks into a two-entry
// in-order queue that drains one write per cycle. B has priority; A wins after STARVE consecutive losses.
module rf_wb_sched #(
  parameter int W      = 8,
  parameter int D      = 3,
  parameter int STARVE = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [D-1:0]      a_addr,
  input  logic [W-1:0]      a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [D-1:0]      b_addr,
  input  logic [W-1:0]      b_data,
  output logic              b_ready,
  input  logic              hold,
  output logic              rf_we,
  output logic [D-1:0]      rf_waddr,
  output logic [W-1:0]      rf_wdata,
  output logic [2**D-1:0]   pend_mask,
  output logic [1:0]        q_count
);

  localparam logic [2:0] STARVE_L = 3'(STARVE);

  logic [1:0]   count;
  logic [2:0]   starve;
  logic [D-1:0] e0_addr, e1_addr;
  logic [W-1:0] e0_data, e1_data;

  logic         not_full;
  logic         a_win;
  logic         push;
  logic         pop;
  logic [1:0]   wr_pos;
  logic [D-1:0] push_addr;
  logic [W-1:0] push_data;

  always_comb begin
    // No pass-through: a slot freed by this cycle's pop is not offered until next cycle.
    not_full  = (count != 2'd2) && !reset;
    a_win     = a_valid && (!b_valid || (starve == STARVE_L));
    a_ready   = not_full && a_win;
    b_ready   = not_full && b_valid && !a_win;
    push      = a_ready || b_ready;
    push_addr = a_ready ? a_addr : b_addr;
    push_data = a_ready ? a_data : b_data;
    pop       = (count != 2'd0) && !hold && !reset;
    wr_pos    = count - {1'b0, pop};
    rf_we     = pop;
    rf_waddr  = e0_addr;
    rf_wdata  = e0_data;
    q_count   = count;
    pend_mask = '0;
    if (!reset) begin
      if (count != 2'd0) pend_mask[e0_addr] = 1'b1;
      if (count == 2'd2) pend_mask[e1_addr] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      count  <= 2'd0;
      starve <= 3'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      // Only a cycle where B actually beat a waiting A counts as a loss for A.
      if (!a_valid || a_ready)
        starve <= 3'd0;
      else if (b_ready && (starve != STARVE_L))
        starve <= starve + 3'd1;
    end
  end

  // Entry payloads need no reset; occupancy is tracked by count alone.
  always_ff @(posedge CLK) begin
    if (pop && (count == 2'd2)) begin
      e0_addr <= e1_addr;
      e0_data <= e1_data;
    end
    if (push) begin
      if (wr_pos == 2'd0) begin
        e0_addr <= push_addr;
        e0_data <= push_data;
      end else begin
        e1_addr <= push_addr;
        e1_data <= push_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Randomized and directed bench for rf_wb_sched against a queue-based behavioural model.
module tb_rf_wb_sched;
  localparam int STARVE = 2;

  logic       CLK = 1'b0;
  logic       reset;
  logic       a_valid, b_valid, hold;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [7:0] pend_mask;
  logic [1:0] q_count;

  rf_wb_sched #(.W(8), .D(3), .STARVE(STARVE)) dut (
    .CLK(CLK), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .hold(hold), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask), .q_count(q_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [2:0] addr; logic [7:0] data; } ent_t;
  ent_t q[$];
  int   starve_m;
  int   checks   = 0;
  int   failures = 0;

  logic       obs_ar, obs_br, obs_we;
  logic [2:0] obs_waddr;
  logic [7:0] obs_wdata, obs_pend;
  logic [1:0] obs_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check every output against the model at negedge, advance model at posedge.
  task automatic cycle(input bit av, input logic [2:0] aa, input logic [7:0] ad,
                       input bit bv, input logic [2:0] ba, input logic [7:0] bd,
                       input bit hd, input bit rs, input bit en);
    bit         full, ea, eb, ewe;
    logic [7:0] epend;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    hold = hd; reset = rs;
    @(negedge CLK);
    full  = (q.size() == 2);
    ea    = !rs && !full && av && (!bv || starve_m == STARVE);
    eb    = !rs && !full && bv && !ea;
    ewe   = !rs && (q.size() > 0) && !hd;
    epend = '0;
    if (!rs) foreach (q[i]) epend[q[i].addr] = 1'b1;
    obs_ar = a_ready; obs_br = b_ready; obs_we = rf_we;
    obs_waddr = rf_waddr; obs_wdata = rf_wdata; obs_pend = pend_mask; obs_cnt = q_count;
    if (en) begin
      check_val("a_ready", 32'(a_ready), 32'(ea));
      check_val("b_ready", 32'(b_ready), 32'(eb));
      check_val("rf_we", 32'(rf_we), 32'(ewe));
      check_val("pend_mask", 32'(pend_mask), 32'(epend));
      check_val("q_count", 32'(q_count), 32'(q.size()));
      if (ewe) begin
        check_val("rf_waddr", 32'(rf_waddr), 32'(q[0].addr));
        check_val("rf_wdata", 32'(rf_wdata), 32'(q[0].data));
      end
    end
    @(posedge CLK);
    #1;
    if (rs) begin
      q.delete();
      starve_m = 0;
    end else begin
      if (ewe) void'(q.pop_front());
      if (ea) q.push_back('{addr: aa, data: ad});
      else if (eb) q.push_back('{addr: ba, data: bd});
      if (!av || ea) starve_m = 0;
      else if (eb && starve_m < STARVE) starve_m++;
    end
  endtask

  task automatic idle(input bit hd);
    cycle(0, 0, 0, 0, 0, 0, hd, 0, 1);
  endtask

  initial begin
    string grants;
    starve_m = 0;
    // Power-on reset: state is unknown before the first edge, so skip model checks here.
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
    check_val("rst_we", 32'(obs_we), 0);
    check_val("rst_pend", 32'(obs_pend), 0);
    idle(0);
    check_val("post_rst_cnt", 32'(obs_cnt), 0);

    // Single ALU write.
    cycle(1, 3'd3, 8'h5A, 0, 0, 0, 0, 0, 1);
    check_val("a_only_ready", 32'(obs_ar), 1);
    idle(0);
    check_val("a_only_we", 32'(obs_we), 1);
    check_val("a_only_addr", 32'(obs_waddr), 3);
    check_val("a_only_data", 32'(obs_wdata), 32'h5A);
    check_val("a_only_pend", 32'(obs_pend), 32'h08);
    idle(0);
    check_val("a_only_cnt", 32'(obs_cnt), 0);

    // Starvation grant pattern.
    grants = "";
    for (int i = 0; i < 6; i++) begin
      cycle(1, 3'(i), 8'(i), 1, 3'(7 - i), 8'(8'h80 + i), 0, 0, 1);
      grants = {grants, obs_ar ? "A" : (obs_br ? "B" : "-")};
    end
    check_val("grant_seq", (grants == "BBABBA") ? 1 : 0, 1);
    idle(0); idle(0);

    // Hold fills the queue; third request waits.
    idle(1);
    cycle(0, 0, 0, 1, 3'd1, 8'h01, 1, 0, 1);
    cycle(0, 0, 0, 1, 3'd2, 8'h02, 1, 0, 1);
    cycle(0, 0, 0, 1, 3'd4, 8'h04, 1, 0, 1);
    check_val("hold_b_ready", 32'(obs_br), 0);
    check_val("hold_cnt", 32'(obs_cnt), 2);
    check_val("hold_pend", 32'(obs_pend), 32'h06);
    cycle(0, 0, 0, 1, 3'd4, 8'h04, 0, 0, 1);
    check_val("rel_addr1", 32'(obs_waddr), 1);
    cycle(0, 0, 0, 1, 3'd4, 8'h04, 0, 0, 1);
    check_val("rel_addr2", 32'(obs_waddr), 2);
    check_val("rel_accept4", 32'(obs_br), 1);
    idle(0); idle(0);

    // Same destination twice; no coalescing.
    cycle(0, 0, 0, 1, 3'd5, 8'h11, 1, 0, 1);
    cycle(0, 0, 0, 1, 3'd5, 8'h22, 1, 0, 1);
    idle(0);
    check_val("dup_first", 32'(obs_wdata), 32'h11);
    check_val("dup_pend_mid", 32'(obs_pend), 32'h20);
    idle(0);
    check_val("dup_second", 32'(obs_wdata), 32'h22);
    idle(0);
    check_val("dup_pend_clr", 32'(obs_pend), 0);

    // Reset with a full, held queue.
    cycle(1, 3'd6, 8'h66, 0, 0, 0, 1, 0, 1);
    cycle(1, 3'd7, 8'h77, 0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 1);
    check_val("midrst_we", 32'(obs_we), 0);
    idle(0);
    check_val("midrst_we_after", 32'(obs_we), 0);
    check_val("midrst_cnt", 32'(obs_cnt), 0);
    check_val("midrst_pend", 32'(obs_pend), 0);

    // Steady stream.
    for (int i = 0; i < 8; i++) begin
      cycle(1, 3'(i), 8'(8'h40 + i), 0, 0, 0, 0, 0, 1);
      if (i > 0) begin
        check_val("stream_cnt", 32'(obs_cnt), 1);
        check_val("stream_data", 32'(obs_wdata), 32'(8'h40 + i - 1));
      end
    end
    idle(0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom),
            $urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom),
            $urandom_range(0, 5) == 0, $urandom_range(0, 199) == 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
